// File: rtl/controller_pkg.sv
// Shared encodings for the instruction-sequencing controller: states, opcodes,
// ALU codes, mux selects, and the decode of control words for each state.
package controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_IF1  = 4'd1,
    S_IF2  = 4'd2,
    S_LD1  = 4'd3,
    S_LD2  = 4'd4,
    S_ST1  = 4'd5,
    S_ST2  = 4'd6,
    S_JMP  = 4'd7,
    S_BZX  = 4'd8,
    S_A1   = 4'd9,
    S_A2   = 4'd10,
    S_A3   = 4'd11
  } state_t;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_JMP = 3'b010;
  localparam logic [2:0] OP_BZ  = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;

  localparam logic [1:0] SEL_DATA_WORD   = 2'd0;
  localparam logic [1:0] SEL_DATA_RESULT = 2'd1;
  localparam logic [1:0] SEL_DATA_DREG   = 2'd2;

  localparam logic [1:0] SEL_AC_DI    = 2'd0;
  localparam logic [1:0] SEL_AC_LS_LO = 2'd1;
  localparam logic [1:0] SEL_AC_LS_HI = 2'd2;

  typedef struct packed {
    logic       pc_en;
    logic       sel_pc;
    logic       sel_address;
    logic       mr;
    logic       mw;
    logic       word_reg_en;
    logic       ls_en;
    logic       rs_en;
    logic       di_en;
    logic [1:0] sel_data;
    logic       sel_alu_src;
    logic [1:0] sel_address_ac;
    logic       enb;
    logic       data_reg_en;
    logic       result_reg_en;
    logic       c_en;
    logic       z_en;
    logic       n_en;
    logic [2:0] operation;
  } ctrl_t;

  // Moore control word for a state; BZX is all-zero here because its branch
  // enables depend on the live Z flag and are added in the top level.
  function automatic ctrl_t decode(input state_t s, input logic [1:0] alu_sel);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF1: begin
        c.mr     = 1'b1;
        c.ls_en  = 1'b1;
        c.pc_en  = 1'b1;
      end
      S_IF2: begin
        c.mr     = 1'b1;
        c.rs_en  = 1'b1;
        c.di_en  = 1'b1;
        c.pc_en  = 1'b1;
      end
      S_LD1: begin
        c.sel_address = 1'b1;
        c.mr          = 1'b1;
        c.word_reg_en = 1'b1;
      end
      S_LD2: begin
        c.sel_data       = SEL_DATA_WORD;
        c.sel_address_ac = SEL_AC_DI;
        c.enb            = 1'b1;
      end
      S_ST1: begin
        c.sel_address_ac = SEL_AC_DI;
        c.data_reg_en    = 1'b1;
      end
      S_ST2: begin
        c.sel_address = 1'b1;
        c.mw          = 1'b1;
      end
      S_JMP: begin
        c.sel_pc = 1'b1;
        c.pc_en  = 1'b1;
      end
      S_A1: begin
        c.sel_address_ac = SEL_AC_LS_HI;
        c.data_reg_en    = 1'b1;
      end
      S_A2: begin
        c.sel_address_ac = SEL_AC_LS_LO;
        c.sel_alu_src    = 1'b0;
        c.result_reg_en  = 1'b1;
        c.c_en           = 1'b1;
        c.z_en           = 1'b1;
        c.n_en           = 1'b1;
        c.operation      = {1'b0, alu_sel};
      end
      S_A3: begin
        c.sel_data       = SEL_DATA_RESULT;
        c.sel_address_ac = SEL_AC_LS_LO;
        c.enb            = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/controller.sv
// Multi-cycle instruction sequencer: fetches one- or two-byte instructions and
// steps the datapath through load, store, jump, branch-on-zero and ALU ops.
//
// state | meaning
// IDLE  | after reset, all controls off
// IF1   | fetch left byte, latch opcode, PC+1
// IF2   | fetch right byte and DI, PC+1
// LD1   | read operand into word reg
// LD2   | write word reg to accumulator
// ST1   | accumulator into data reg
// ST2   | write data reg to memory
// JMP   | load PC with target
// BZX   | load PC with target if Z
// A1    | first operand into data reg
// A2    | ALU op, update result and flags
// A3    | write result to accumulator
module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zFlag,
  output logic       pcEn,
  output logic       selPC,
  output logic       selAddress,
  output logic       mr,
  output logic       mw,
  output logic       wordRegEn,
  output logic       LSEn,
  output logic       RSEn,
  output logic       DIEn,
  output logic [1:0] selData,
  output logic       selALUsrc,
  output logic [1:0] selAddressAC,
  output logic       enb,
  output logic       dataRegEn,
  output logic       resultRegEn,
  output logic       CEn,
  output logic       ZEn,
  output logic       NEn,
  output logic [2:0] operation
);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       bz_take;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: state_d = S_IF1;
      S_IF1: begin
        op_d    = opcode;
        state_d = opcode[2] ? S_A1 : S_IF2;
      end
      S_IF2: begin
        case (op_q)
          OP_LDA:  state_d = S_LD1;
          OP_STA:  state_d = S_ST1;
          OP_JMP:  state_d = S_JMP;
          default: state_d = S_BZX;
        endcase
      end
      S_LD1: state_d = S_LD2;
      S_ST1: state_d = S_ST2;
      S_A1:  state_d = S_A2;
      S_A2:  state_d = S_A3;
      S_LD2, S_ST2, S_JMP, S_BZX, S_A3: state_d = S_IF1;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so decode the state being entered.
    ctrl_d = decode(state_d, op_d[1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bz_take = (state_q == S_BZX) && zFlag;

  assign pcEn         = ctrl_q.pc_en | bz_take;
  assign selPC        = ctrl_q.sel_pc | bz_take;
  assign selAddress   = ctrl_q.sel_address;
  assign mr           = ctrl_q.mr;
  assign mw           = ctrl_q.mw;
  assign wordRegEn    = ctrl_q.word_reg_en;
  assign LSEn         = ctrl_q.ls_en;
  assign RSEn         = ctrl_q.rs_en;
  assign DIEn         = ctrl_q.di_en;
  assign selData      = ctrl_q.sel_data;
  assign selALUsrc    = ctrl_q.sel_alu_src;
  assign selAddressAC = ctrl_q.sel_address_ac;
  assign enb          = ctrl_q.enb;
  assign dataRegEn    = ctrl_q.data_reg_en;
  assign resultRegEn  = ctrl_q.result_reg_en;
  assign CEn          = ctrl_q.c_en;
  assign ZEn          = ctrl_q.z_en;
  assign NEn          = ctrl_q.n_en;
  assign operation    = ctrl_q.operation;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the instruction sequencer: walks each instruction class
// and checks the full control word every cycle against hand-derived values.
module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic       zFlag;
  logic       pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn;
  logic [1:0] selData, selAddressAC;
  logic       selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn;
  logic [2:0] operation;

  typedef struct packed {
    logic       pcEn;
    logic       selPC;
    logic       selAddress;
    logic       mr;
    logic       mw;
    logic       wordRegEn;
    logic       LSEn;
    logic       RSEn;
    logic       DIEn;
    logic [1:0] selData;
    logic       selALUsrc;
    logic [1:0] selAddressAC;
    logic       enb;
    logic       dataRegEn;
    logic       resultRegEn;
    logic       CEn;
    logic       ZEn;
    logic       NEn;
    logic [2:0] operation;
  } ov_t;

  ov_t obs;
  int  n_vec = 0;
  int  n_err = 0;

  controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zFlag(zFlag),
    .pcEn(pcEn), .selPC(selPC), .selAddress(selAddress), .mr(mr), .mw(mw),
    .wordRegEn(wordRegEn), .LSEn(LSEn), .RSEn(RSEn), .DIEn(DIEn),
    .selData(selData), .selALUsrc(selALUsrc), .selAddressAC(selAddressAC),
    .enb(enb), .dataRegEn(dataRegEn), .resultRegEn(resultRegEn),
    .CEn(CEn), .ZEn(ZEn), .NEn(NEn), .operation(operation)
  );

  always #5 clk = ~clk;

  assign obs = '{pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn,
                 selData, selALUsrc, selAddressAC, enb, dataRegEn, resultRegEn,
                 CEn, ZEn, NEn, operation};

  function automatic ov_t e_zero();
    ov_t o = '0;
    return o;
  endfunction
  function automatic ov_t e_if1();
    ov_t o = '0; o.mr = 1; o.LSEn = 1; o.pcEn = 1;
    return o;
  endfunction
  function automatic ov_t e_if2();
    ov_t o = '0; o.mr = 1; o.RSEn = 1; o.DIEn = 1; o.pcEn = 1;
    return o;
  endfunction
  function automatic ov_t e_ld1();
    ov_t o = '0; o.selAddress = 1; o.mr = 1; o.wordRegEn = 1;
    return o;
  endfunction
  function automatic ov_t e_ld2();
    ov_t o = '0; o.enb = 1;
    return o;
  endfunction
  function automatic ov_t e_st1();
    ov_t o = '0; o.dataRegEn = 1;
    return o;
  endfunction
  function automatic ov_t e_st2();
    ov_t o = '0; o.selAddress = 1; o.mw = 1;
    return o;
  endfunction
  function automatic ov_t e_jmp();
    ov_t o = '0; o.selPC = 1; o.pcEn = 1;
    return o;
  endfunction
  function automatic ov_t e_a1();
    ov_t o = '0; o.selAddressAC = 2'd2; o.dataRegEn = 1;
    return o;
  endfunction
  function automatic ov_t e_a2(input logic [2:0] op);
    ov_t o = '0; o.selAddressAC = 2'd1; o.resultRegEn = 1;
    o.CEn = 1; o.ZEn = 1; o.NEn = 1; o.operation = op;
    return o;
  endfunction
  function automatic ov_t e_a3();
    ov_t o = '0; o.selData = 2'd1; o.selAddressAC = 2'd1; o.enb = 1;
    return o;
  endfunction

  task automatic check(input string tag, input ov_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 3'b000;
    zFlag  = 1'b0;

    // reset held two cycles
    step(); check("rst_c1", e_zero());
    step(); check("rst_c2", e_zero());
    reset = 1'b0;
    #1 check("idle", e_zero());
    step(); check("if1_first", e_if1());

    // LDA; opcode changed after IF1 to prove it was latched
    opcode = 3'b000;
    step(); check("lda_if2", e_if2());
    opcode = 3'b111;
    step(); check("lda_ld1", e_ld1());
    step(); check("lda_ld2", e_ld2());
    step(); check("lda_if1", e_if1());

    // SUB
    opcode = 3'b101;
    step(); check("sub_a1", e_a1());
    opcode = 3'b000;
    step(); check("sub_a2", e_a2(3'b001));
    step(); check("sub_a3", e_a3());
    step(); check("sub_if1", e_if1());

    // NOT
    opcode = 3'b111;
    step(); check("not_a1", e_a1());
    step(); check("not_a2", e_a2(3'b011));
    step(); check("not_a3", e_a3());
    step(); check("not_if1", e_if1());

    // AND
    opcode = 3'b110;
    step(); check("and_a1", e_a1());
    step(); check("and_a2", e_a2(3'b010));
    step(); check("and_a3", e_a3());
    step(); check("and_if1", e_if1());

    // JMP: 3 cycles
    opcode = 3'b010;
    step(); check("jmp_if2", e_if2());
    step(); check("jmp_jmp", e_jmp());
    step(); check("jmp_if1", e_if1());

    // BZ taken, then Z falls within BZX
    opcode = 3'b011;
    zFlag  = 1'b1;
    step(); check("bz1_if2", e_if2());
    step(); check("bz1_bzx", e_jmp());
    zFlag = 1'b0;
    #1 check("bz1_zdrop", e_zero());
    step(); check("bz1_if1", e_if1());

    // BZ not taken
    opcode = 3'b011;
    zFlag  = 1'b0;
    step(); check("bz0_if2", e_if2());
    step(); check("bz0_bzx", e_zero());
    step(); check("bz0_if1", e_if1());

    // STA complete
    opcode = 3'b001;
    step(); check("sta_if2", e_if2());
    step(); check("sta_st1", e_st1());
    step(); check("sta_st2", e_st2());
    step(); check("sta_if1", e_if1());

    // STA interrupted by async reset in ST1
    opcode = 3'b001;
    step(); check("sta2_if2", e_if2());
    step(); check("sta2_st1", e_st1());
    #2 reset = 1'b1;
    #1 check("async_rst", e_zero());
    step(); check("rst_hold", e_zero());
    reset = 1'b0;
    #1 check("idle2", e_zero());
    step(); check("if1_restart", e_if1());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameters: none; all widths and encodings are fixed and come from controller_pkg.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  3  instruction opcode, combinational memory output bits [7:5] (datapath toCU).
REQ-005 zFlag  in  1  datapath Z flag register output.
REQ-006 pcEn  out  1  PC load enable.
REQ-007 selPC  out  1  PC source: 0=PC+1, 1={LS[4:0],RS}.
REQ-008 selAddress  out  1  memory address: 0=PC, 1={LS[4:0],RS}.
REQ-009 mr  out  1  memory read.
REQ-010 mw  out  1  memory write.
REQ-011 wordRegEn  out  1  word register load.
REQ-012 LSEn  out  1  instruction left-byte register load.
REQ-013 RSEn  out  1  instruction right-byte register load.
REQ-014 DIEn  out  1  DI register load from LS[4:0].
REQ-015 selData  out  2  accumulator write data: 0=word reg, 1=result reg, 2=data reg.
REQ-016 selALUsrc  out  1  ALU B source: 0=data reg, 1=word reg.
REQ-017 selAddressAC  out  2  accumulator index: 0=DI[4:3], 1=LS[1:0], 2=LS[3:2].
REQ-018 enb  out  1  accumulator write enable.
REQ-019 dataRegEn  out  1  data register load.
REQ-020 resultRegEn  out  1  result register load.
REQ-021 CEn  out  1  carry flag load.
REQ-022 ZEn  out  1  zero flag load.
REQ-023 NEn  out  1  negative flag load.
REQ-024 operation  out  3  ALU function code.

Function
REQ-025 Opcodes: 000 LDA, 001 STA, 010 JMP, 011 BZ (two-byte); 100 ADD, 101 SUB, 110 AND, 111 NOT (one-byte).
REQ-026 The FSM is Moore, except that pcEn/selPC in BZX also depend on zFlag; outputs not listed for a state are 0, and selData, selAddressAC and operation are 0 unless listed.
REQ-027 IDLE: all outputs 0; next state is IF1.
REQ-028 IF1: mr, LSEn, pcEn (selAddress=0, selPC=0); opcode is latched into internal opReg; next state is IF2 if opcode[2]=0, otherwise A1.
REQ-029 IF2: mr, RSEn, DIEn, pcEn; next state by opReg: LD1, ST1, JMP or BZX.
REQ-030 LD1: selAddress=1, mr, wordRegEn; next state LD2.
REQ-031 LD2: selData=0, selAddressAC=0, enb; next state IF1.
REQ-032 ST1: selAddressAC=0, dataRegEn; next state ST2.
REQ-033 ST2: selAddress=1, mw; next state IF1.
REQ-034 JMP: selPC=1, pcEn; next state IF1.
REQ-035 BZX: if zFlag=1 (sampled this cycle), selPC=1 and pcEn; if zFlag=0, no outputs; next state IF1 in both cases.
REQ-036 A1: selAddressAC=2, dataRegEn; next state A2.
REQ-037 A2: selAddressAC=1, selALUsrc=0, resultRegEn, CEn, ZEn, NEn, operation={1'b0,opReg[1:0]}; next state A3.
REQ-038 A3: selData=1, selAddressAC=1, enb; next state IF1.
REQ-039 Latency from IF1 to the next IF1 is 4 cycles for LDA, STA and ALU ops, and 3 cycles for JMP and BZ; there is no stall input.
REQ-040 mr and mw are never asserted in the same cycle, and enb is asserted only in LD2 and A3.

Reset
REQ-041 Asserting reset forces state=IDLE and opReg=000 immediately, including mid-instruction; every output then reads 0.
REQ-042 After reset deasserts, the first rising edge enters IF1.

Structure
REQ-043 controller_pkg holds the state enum, the opcode constants, the ALU function codes (000 ADD, 001 SUB, 010 AND, 011 NOT) and the selData/selAddressAC encodings.
REQ-044 controller is a single module with no sub-module, built as a state register, opReg, next-state logic and output decode.

Verification
REQ-045 Reset held 2 cycles, then released -> all outputs 0 during reset; IDLE, then IF1 with mr=pcEn=LSEn=1.
REQ-046 opcode=000 in IF1 -> sequence IF2, LD1 (selAddress=1, mr, wordRegEn), LD2 (enb, selData=0), then IF1; 4 cycles total.
REQ-047 opcode=101 in IF1 -> A1, A2 with operation=001 and CEn=ZEn=NEn=1, A3 with enb=1 and selData=1, then IF1.
REQ-048 opcode=011 with zFlag=1 in BZX -> pcEn=selPC=1; repeated with zFlag=0 -> pcEn=0; both cases return to IF1.
REQ-049 reset asserted asynchronously in ST1 -> outputs drop to 0 before the next edge; mw is never asserted; the FSM restarts at IDLE.
